// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage holding the MEM/WB register; drives a req/ack word bus
// with a bounded wait and stalls upstream stages while an access is pending.
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  WB,
  input  logic [2:0]  M,
  input  logic [31:0] ALURes,
  input  logic [31:0] DataIn,
  input  logic [4:0]  RdRt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [1:0]  WBReg,
  output logic [31:0] MemDataReg,
  output logic [31:0] ALUReg,
  output logic [4:0]  RdRtReg,
  output logic        misalign,
  output logic        bus_err
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic {IDLE, BUS} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] lwb;
  logic [31:0] lalu;
  logic [4:0] lrd;
  logic memop, aligned, start, last, unused_branch;
  assign unused_branch = M[0];
  assign mem_req = state == BUS;
  always_comb begin
    memop = M[2] | M[1];
    aligned = ALURes[1:0] == 2'b00;
    start = state == IDLE && memop && aligned;
    last = cnt == CW'(TIMEOUT - 1);
    stall = start | (state == BUS && !mem_ack && !last);
    state_n = state == IDLE ? (start ? BUS : IDLE) : ((mem_ack || last) ? IDLE : BUS);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      {mem_we, mem_addr, mem_wdata, lwb, lalu, lrd} <= '0;
      {WBReg, MemDataReg, ALUReg, RdRtReg, misalign, bus_err} <= '0;
    end else begin
      misalign <= state == IDLE && memop && !aligned;
      bus_err <= state == BUS && !mem_ack && last;
      if (state == IDLE) begin
        cnt <= '0;
        if (start) begin
          {mem_we, mem_addr, mem_wdata} <= {M[1], ALURes[31:2], DataIn};
          {lwb, lalu, lrd} <= {WB, ALURes, RdRt};
          {WBReg, MemDataReg, ALUReg, RdRtReg} <= '0;
        end else begin
          // misaligned memory ops reach MEM/WB with their write-back disabled
          WBReg <= memop ? 2'b00 : WB;
          MemDataReg <= '0;
          ALUReg <= ALURes;
          RdRtReg <= RdRt;
        end
      end else if (mem_ack || last) begin
        WBReg <= mem_ack ? lwb : 2'b00;
        MemDataReg <= (mem_ack && !mem_we) ? mem_rdata : '0;
        ALUReg <= lalu;
        RdRtReg <= lrd;
      end else begin
        {WBReg, MemDataReg, ALUReg, RdRtReg} <= '0;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage; a per-op reference model predicts
// per-cycle bus/stall behaviour and MEM/WB contents, a negedge monitor compares.
module tb_mem_stage;
  localparam int T = 15;
  logic clk = 0, rst_n = 0;
  logic [1:0] WB = 0;
  logic [2:0] M = 0;
  logic [31:0] ALURes = 0, DataIn = 0, mem_rdata = 0;
  logic [4:0] RdRt = 0;
  logic mem_ack = 0;
  logic mem_req, mem_we, stall, misalign, bus_err;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, MemDataReg, ALUReg;
  logic [1:0] WBReg;
  logic [4:0] RdRtReg;
  int n_chk = 0, n_fail = 0;
  bit mon_en = 0;

  typedef struct {logic stall, req, we; logic [29:0] addr; logic [31:0] wdata;} ctl_t;
  typedef struct {logic [1:0] wb; logic [31:0] alu, md; logic [4:0] rd; logic mis, be, ar;} wb_t;
  ctl_t q_ctl[$];
  wb_t q_wb[$];

  mem_stage #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .WB(WB), .M(M), .ALURes(ALURes), .DataIn(DataIn), .RdRt(RdRt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .WBReg(WBReg),
    .MemDataReg(MemDataReg), .ALUReg(ALUReg), .RdRtReg(RdRtReg), .misalign(misalign),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", n, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    ctl_t c;
    wb_t w;
    if (mon_en && q_ctl.size() > 0) begin
      c = q_ctl.pop_front();
      chk("stall", stall, c.stall);
      chk("mem_req", mem_req, c.req);
      if (c.req) begin
        chk("mem_we", mem_we, c.we);
        chk("mem_addr", mem_addr, c.addr);
        chk("mem_wdata", mem_wdata, c.wdata);
      end
      if (q_wb.size() == 0) chk("wb_queue_nonempty", 0, 1);
      else begin
        w = q_wb.pop_front();
        chk("WBReg", WBReg, w.wb);
        chk("MemDataReg", MemDataReg, w.md);
        chk("misalign", misalign, w.mis);
        chk("bus_err", bus_err, w.be);
        if (w.ar) begin
          chk("ALUReg", ALUReg, w.alu);
          chk("RdRtReg", RdRtReg, w.rd);
        end
      end
    end
  end

  // One pipeline cycle: drive inputs, record what this cycle should show and what MEM/WB loads.
  task automatic step(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu, din,
                      input logic [4:0] rd, input logic ack, input logic [31:0] rdata,
                      input ctl_t c, input wb_t w);
    @(posedge clk);
    #1;
    {WB, M, ALURes, DataIn, RdRt, mem_ack, mem_rdata} = {wb, m, alu, din, rd, ack, rdata};
    q_ctl.push_back(c);
    q_wb.push_back(w);
  endtask

  // d = BUS cycle index at which ack arrives; d >= T means no ack ever.
  task automatic run_op(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu, din,
                        input logic [4:0] rd, input int d);
    ctl_t c;
    wb_t bub, w;
    logic [31:0] rdata;
    int nbus;
    bub = '{wb: 2'b00, alu: 0, md: 0, rd: 0, mis: 0, be: 0, ar: 1};
    c = '{stall: 0, req: 0, we: 0, addr: 0, wdata: 0};
    if (!(m[2] || m[1])) begin
      w = '{wb: wb, alu: alu, md: 0, rd: rd, mis: 0, be: 0, ar: 1};
      step(wb, m, alu, din, rd, 1'($urandom_range(0, 1)), $urandom, c, w);
    end else if (alu[1:0] != 0) begin
      w = '{wb: 2'b00, alu: alu, md: 0, rd: rd, mis: 1, be: 0, ar: 1};
      step(wb, m, alu, din, rd, 1'($urandom_range(0, 1)), $urandom, c, w);
    end else begin
      c.stall = 1;
      step(wb, m, alu, din, rd, 1'($urandom_range(0, 1)), $urandom, c, bub);
      nbus = d < T ? d + 1 : T;
      for (int k = 0; k < nbus; k++) begin
        rdata = $urandom;
        c = '{stall: (k < d) && (k < T - 1), req: 1, we: m[1], addr: alu[31:2], wdata: din};
        if (k != nbus - 1) w = bub;
        else if (k == d) w = '{wb: wb, alu: alu, md: m[1] ? 0 : rdata, rd: rd, mis: 0, be: 0, ar: 1};
        else w = '{wb: 2'b00, alu: 0, md: 0, rd: 0, mis: 0, be: 1, ar: 0};
        step(wb, m, alu, din, rd, k == d, rdata, c, w);
      end
    end
  endtask

  initial begin
    int kind, d;
    logic [2:0] m;
    logic [31:0] a;
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_WBReg", WBReg, 0);
    chk("rst_MemDataReg", MemDataReg, 0);
    chk("rst_ALUReg", ALUReg, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_bus_err", bus_err, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    {WB, M, ALURes, RdRt} = {2'b11, 3'b100, 32'h100, 5'd9};
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_mem_req", mem_req, 1);
    chk("pre_rst_mem_addr", mem_addr, 32'h40);
    #2 rst_n = 0;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_mem_addr", mem_addr, 0);
    chk("async_rst_mem_we", mem_we, 0);
    chk("async_rst_WBReg", WBReg, 0);
    chk("async_rst_RdRtReg", RdRtReg, 0);
    {WB, M, ALURes, RdRt} = '0;
    @(negedge clk) rst_n = 1;
    q_wb.push_back('{wb: 0, alu: 0, md: 0, rd: 0, mis: 0, be: 0, ar: 1});
    mon_en = 1;
    run_op(2'b10, 3'b000, 32'h1234, 32'h0, 5'd5, 0);
    run_op(2'b11, 3'b100, 32'h40, 32'h0, 5'd7, 0);
    run_op(2'b00, 3'b010, 32'h80, 32'hCAFEF00D, 5'd0, 3);
    run_op(2'b11, 3'b100, 32'h42, 32'h0, 5'd3, 0);
    run_op(2'b11, 3'b100, 32'h44, 32'h0, 5'd4, 1000);
    run_op(2'b11, 3'b101, 32'h48, 32'h0, 5'd6, T - 1);
    run_op(2'b01, 3'b110, 32'h4C, 32'h5555AAAA, 5'd8, 1);
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      m = {kind == 0 ? 2'b00 : 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1))};
      if (kind == 2) a[1:0] = 0;
      else if (kind == 1 && a[1:0] == 0) a[0] = 1;
      d = $urandom_range(0, 9) == 0 ? (($urandom_range(0, 1) == 1) ? T - 1 : T + 5)
                                    : $urandom_range(0, 4);
      run_op(2'($urandom), m, a, $urandom, 5'($urandom), d);
    end
    run_op(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 0);
    @(negedge clk);
    #1;
    chk("ctl_queue_drained", q_ctl.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
